// File: rtl/phased_pkg.sv
// phased_pkg: shared state encoding, limits and defaults for the phased burst generator.
package phased_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int MIN_PER   = 2;
   localparam int DEF_N_CH  = 8;
   localparam int DEF_DLY_W = 8;
   localparam int DEF_PER_W = 16;

   function automatic int delay_width(input int dly_w, input int n_ch);
      return dly_w + $clog2(n_ch);
   endfunction

endpackage

// File: rtl/phased_burst_gen_ch.sv
// phased_ch: one transducer channel with delay countdown, phase counter and pulse counter.
// z is registered from the next-cycle counter values so it lines up with the counters.
module phased_ch
   import phased_pkg::*;
#(
   parameter int DW    = 11,
   parameter int PER_W = DEF_PER_W
) (
   input  logic             sys_clk,
   input  logic             sys_rstn,
   input  logic             run,
   input  logic             load,
   input  logic             mask,
   input  logic [DW-1:0]    delay,
   input  logic [PER_W-1:0] period,
   input  logic [PER_W-1:0] high,
   input  logic [7:0]       burst_len,
   output logic             z,
   output logic             ch_done
);

   logic [DW-1:0]    dly, dly_s;
   logic [PER_W-1:0] ph, ph_s;
   logic [7:0]       pc, pc_s;
   logic             fin, fin_s, wrap;

   always_comb begin
      wrap  = dly == '0 && !fin && ph == period - 1'b1;
      dly_s = load ? delay : dly != '0 ? dly - 1'b1 : dly;
      ph_s  = load ? '0 : (dly != '0 || fin) ? ph : wrap ? '0 : ph + 1'b1;
      pc_s  = load ? '0 : wrap ? pc + 8'd1 : pc;
      fin_s = load ? 1'b0 : fin || (wrap && burst_len != 8'd0 && pc + 8'd1 == burst_len);
   end

   assign ch_done = fin_s;

   always_ff @(posedge sys_clk) begin
      if (sys_rstn || !run) begin
         dly <= '0;
         ph  <= '0;
         pc  <= '0;
         fin <= 1'b0;
         z   <= 1'b0;
      end else begin
         dly <= dly_s;
         ph  <= ph_s;
         pc  <= pc_s;
         fin <= fin_s;
         z   <= mask && dly_s == '0 && !fin_s && ph_s < high;
      end
   end

endmodule

// File: rtl/phased_burst_gen.sv
// phased_burst_gen: steered multi-channel pulse burst generator with per-channel delay.
// Optional PHASED_CH_MASK_EN adds a ch_mask input latched at start.
module phased_burst_gen
   import phased_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int DLY_W = DEF_DLY_W,
   parameter int PER_W = DEF_PER_W
) (
   input  logic             sys_clk,
   input  logic             sys_rstn,
   input  logic             start,
   input  logic             en,
   input  logic [DLY_W-1:0] step,
   input  logic             dir,
   input  logic [PER_W-1:0] period,
   input  logic [PER_W-1:0] high,
   input  logic [7:0]       burst_len,
   output logic [N_CH-1:0]  z,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
`ifdef PHASED_CH_MASK_EN
   ,
   input  logic [N_CH-1:0]  ch_mask
`endif
);

   localparam int DW = delay_width(DLY_W, N_CH);

   state_t           state, state_n;
   logic [DLY_W-1:0] step_q, step_c;
   logic             dir_q, dir_c;
   logic [PER_W-1:0] per_q, per_c, high_q, high_c;
   logic [7:0]       bl_q, bl_c;
   logic [N_CH-1:0]  mask_c, ch_done;
   logic             ok, acc, rej, run, done_n;

   assign ok  = start && en && period >= PER_W'(MIN_PER);
   assign acc = state == IDLE && ok;
   assign rej = state == IDLE && start && !ok;

   // Channels load in the accepting cycle, so they see the incoming config directly.
   assign step_c = acc ? step : step_q;
   assign dir_c  = acc ? dir : dir_q;
   assign per_c  = acc ? period : per_q;
   assign high_c = acc ? high : high_q;
   assign bl_c   = acc ? burst_len : bl_q;

`ifdef PHASED_CH_MASK_EN
   logic [N_CH-1:0] mask_q;
   always_ff @(posedge sys_clk) begin
      mask_q <= sys_rstn ? '1 : acc ? ch_mask : mask_q;
   end
   assign mask_c = acc ? ch_mask : mask_q;
`else
   assign mask_c = '1;
`endif

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      if (state == IDLE) state_n = acc ? RUN : IDLE;
      else if (!en) state_n = IDLE;
      else if (&ch_done) begin
         state_n = IDLE;
         done_n  = 1'b1;
      end
   end

   assign run  = state_n == RUN;
   assign busy = state == RUN;

   always_ff @(posedge sys_clk) begin
      if (sys_rstn) begin
         state   <= IDLE;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         step_q  <= '0;
         dir_q   <= 1'b0;
         per_q   <= '0;
         high_q  <= '0;
         bl_q    <= '0;
      end else begin
         state   <= state_n;
         done    <= done_n;
         cfg_err <= rej;
         if (acc) begin
            step_q <= step;
            dir_q  <= dir;
            per_q  <= period;
            high_q <= high;
            bl_q   <= burst_len;
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [DW-1:0] delay;
      assign delay = (dir_c ? DW'(N_CH - 1 - i) : DW'(i)) * DW'(step_c);
      phased_ch #(.DW(DW), .PER_W(PER_W)) u_ch (
         .sys_clk   (sys_clk),
         .sys_rstn  (sys_rstn),
         .run       (run),
         .load      (acc),
         .mask      (mask_c[i]),
         .delay     (delay),
         .period    (per_c),
         .high      (high_c),
         .burst_len (bl_c),
         .z         (z[i]),
         .ch_done   (ch_done[i])
      );
   end

endmodule

// File: tb/tb_phased_burst_gen.sv
// tb_phased_burst_gen: scoreboard bench with a window/modulo reference model (PHASED_CH_MASK_EN aware).
module tb_phased_burst_gen;

   localparam int N = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rstn, start, en, dir;
   logic [7:0]    step, burst_len;
   logic [15:0]   period, high;
   logic [N-1:0]  z, mask_in;
   logic          busy, done, cfg_err;

   typedef struct packed {
      logic [N-1:0] z;
      logic         busy;
      logic         done;
      logic         err;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int   n_chk = 0, n_fail = 0, cyc_n = 0;

   bit           m_run = 1'b0;
   int           m_t, m_step, m_dir, m_per, m_high, m_bl;
   logic [N-1:0] m_mask;

   always #5 sys_clk = ~sys_clk;

   phased_burst_gen #(.N_CH(N), .DLY_W(8), .PER_W(16)) dut (
      .sys_clk   (sys_clk),
      .sys_rstn  (sys_rstn),
      .start     (start),
      .en        (en),
      .step      (step),
      .dir       (dir),
      .period    (period),
      .high      (high),
      .burst_len (burst_len),
      .z         (z),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
`ifdef PHASED_CH_MASK_EN
      ,
      .ch_mask   (mask_in)
`endif
   );

   // Channel i is on inside [d_i, d_i + bl*per) for the first `high` cycles of each period.
   function automatic logic [N-1:0] model_z();
      logic [N-1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         int d;
         d = (m_dir != 0 ? N - 1 - i : i) * m_step;
         if (m_t >= d && (m_bl == 0 || m_t < d + m_bl * m_per) && (m_t - d) % m_per < m_high)
            r[i] = m_mask[i];
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, got, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      cyc_n++;
      if (q.size() > 0) begin
         e_mon = q.pop_front();
         chk("z", 32'(z), 32'(e_mon.z));
         chk("busy", 32'(busy), 32'(e_mon.busy));
         chk("done", 32'(done), 32'(e_mon.done));
         chk("cfg_err", 32'(cfg_err), 32'(e_mon.err));
      end
   end

   task automatic cyc(input logic r, input logic s, input logic e);
      exp_t x;
      sys_rstn = r;
      start    = s;
      en       = e;
      x.done   = 1'b0;
      x.err    = 1'b0;
      if (r) m_run = 1'b0;
      else if (!m_run) begin
         if (s) begin
            if (e && period >= 2) begin
               m_run  = 1'b1;
               m_t    = 0;
               m_step = int'(step);
               m_dir  = int'(dir);
               m_per  = int'(period);
               m_high = int'(high);
               m_bl   = int'(burst_len);
               m_mask = mask_in;
            end else x.err = 1'b1;
         end
      end else if (!e) m_run = 1'b0;
      else begin
         m_t++;
         if (m_bl != 0 && m_t == (N - 1) * m_step + m_bl * m_per) begin
            m_run  = 1'b0;
            x.done = 1'b1;
         end
      end
      x.busy = m_run;
      x.z    = m_run ? model_z() : '0;
      @(posedge sys_clk);
      q.push_back(x);
      #1;
   endtask

   task automatic set_cfg(input int st, input int d, input int p, input int h, input int b);
      step      = 8'(st);
      dir       = d[0];
      period    = 16'(p);
      high      = 16'(h);
      burst_len = 8'(b);
   endtask

   task automatic idle(input int n, input logic e);
      repeat (n) cyc(1'b0, 1'b0, e);
   endtask

   initial begin
      sys_rstn = 1'b1;
      start    = 1'b0;
      en       = 1'b0;
      mask_in  = '1;
      set_cfg(0, 0, 10, 5, 0);
      @(posedge sys_clk);
      #1;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      idle(2, 1'b1);
      set_cfg(3, 0, 10, 5, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(45, 1'b1);
      set_cfg(3, 1, 10, 5, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(45, 1'b1);
      set_cfg(3, 0, 1, 5, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(3, 1'b1);
      set_cfg(3, 0, 10, 5, 2);
      cyc(1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      set_cfg(2, 0, 7, 3, 0);
      cyc(1'b0, 1'b1, 1'b1);
      idle(50, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
      set_cfg(3, 0, 10, 12, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(5, 1'b1);
      set_cfg(1, 1, 4, 1, 1);
      cyc(1'b0, 1'b1, 1'b1);
      idle(40, 1'b1);
      set_cfg(2, 1, 6, 0, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(30, 1'b1);
      set_cfg(3, 0, 10, 5, 2);
      cyc(1'b0, 1'b1, 1'b1);
      idle(7, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      idle(45, 1'b1);
      for (int k = 0; k < 25; k++) begin
         set_cfg($urandom_range(5), $urandom_range(1), $urandom_range(12, 2), $urandom_range(14), $urandom_range(3));
`ifdef PHASED_CH_MASK_EN
         mask_in = N'($urandom);
`endif
         cyc(1'b0, 1'b1, 1'b1);
         for (int c = 0; c < 80; c++) begin
            bit e2;
            e2 = $urandom_range(149) != 0;
            if ($urandom_range(19) == 0)
               set_cfg($urandom_range(5), $urandom_range(1), $urandom_range(12, 1), $urandom_range(14), $urandom_range(3));
            cyc(1'b0, $urandom_range(29) == 0, e2);
         end
         cyc(1'b0, 1'b0, 1'b0);
      end
      repeat (3) @(posedge sys_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/phased_burst_gen.md
PHASED_BURST_GEN -- requirements
Module: phased_burst_gen

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of transducer channels (2..32).
REQ-002 SHALL have parameter DLY_W, default 8, width of the inter-channel delay step.
REQ-003 SHALL have parameter PER_W, default 16, width of the period and high-time fields.
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rstn  input  1  reset, synchronous and active-high (asserted = 1).
REQ-006 SHALL have port start  input  1  single-cycle pulse that latches the configuration and begins a burst.
REQ-007 SHALL have port en  input  1  run enable; low aborts any burst.
REQ-008 SHALL have port step  input  DLY_W  delay increment between adjacent channels, in cycles.
REQ-009 SHALL have port dir  input  1  steering direction: 0 gives d_i = i*step; 1 gives d_i = (N_CH-1-i)*step.
REQ-010 SHALL have port period  input  PER_W  pulse period in cycles.
REQ-011 SHALL have port high  input  PER_W  pulse high time in cycles.
REQ-012 SHALL have port burst_len  input  8  pulses per channel; 0 means continuous.
REQ-013 SHALL have port z  output  N_CH  drive outputs.
REQ-014 SHALL have port busy  output  1  high while a burst is running.
REQ-015 SHALL have port done  output  1  one-cycle pulse at normal burst completion.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement states IDLE and RUN.
REQ-018 SHALL move IDLE->RUN on start=1, en=1 and period>=2, latching step, dir, period, high and burst_len in that same cycle.
REQ-019 SHALL, on start with period<2 or en=0, stay in IDLE and pulse cfg_err in the next cycle.
REQ-020 SHALL ignore start while in RUN; the latched configuration is not changed.
REQ-021 SHALL define t=0 as the first cycle after the accepting start edge; channel i is active for t in [d_i, d_i+burst_len*period).
REQ-022 SHALL compute d_i at full width DLY_W+clog2(N_CH), with no truncation.
REQ-023 SHALL drive z[i]=1 when channel i is active and ((t-d_i) mod period) < high, and z[i]=0 otherwise; all outputs are registered.
REQ-024 SHALL drive z[i] constantly high while active when high>=period, and constantly low when high=0.
REQ-025 SHALL, when burst_len=0, keep every channel active from d_i onward until en falls, with no done pulse.
REQ-026 SHALL, in the cycle t = d_max + burst_len*period, pulse done, deassert busy and return to IDLE.
REQ-027 SHALL, when en falls during RUN, force z low and busy low and enter IDLE in the next cycle, with no done pulse.
REQ-028 SHALL produce a phase counter that wraps from period-1 to 0 without a gap cycle.
REQ-029 SHALL hold busy=1 for the whole of RUN, including delay-wait cycles with all z low.

Reset
REQ-030 SHALL, when sys_rstn=1 at a clock edge, set state to IDLE and clear z, busy, done, cfg_err and all counters; reset overrides start.
REQ-031 SHALL abort any burst on reset mid-burst, with outputs low in the cycle after the reset edge.

Configuration
REQ-032 SHALL use macro PHASED_CH_MASK_EN: when defined, add input ch_mask[N_CH-1:0], latched at start, with z[i] forced low when ch_mask[i]=0 and timing unchanged.
REQ-033 SHALL, when PHASED_CH_MASK_EN is undefined, have no ch_mask port and enable all channels.

Structure
REQ-034 SHALL place the state encoding, the minimum-period constant (2) and the default parameter values in shared package phased_pkg.
REQ-035 SHALL instantiate sub-module phased_ch once per channel; each instance holds a delay countdown, a phase counter and a pulse counter, and reports z and ch_done.

Verification
REQ-036 SHALL be verified with N_CH=8, period=10, high=5, step=3, dir=0, burst_len=2: z[0] high t=0-4 and 10-14; z[1] high t=3-7 and 13-17; z[7] high t=21-25 and 31-35; done at t=41.
REQ-037 SHALL be verified with the same stimulus but dir=1: z[7] starts at t=0, z[0] starts at t=21, and done at t=41.
REQ-038 SHALL be verified with period=1 on start: cfg_err pulses once, busy stays 0 and z stays 0.
REQ-039 SHALL be verified with burst_len=0 and en dropped at t=50: z all 0 and busy 0 from t=51, with no done.
REQ-040 SHALL be verified with high=12, period=10: each z[i] is steady high across its active window; a second start at t=5 is ignored.
REQ-041 SHALL be verified with sys_rstn=1 at t=7 mid-burst: all outputs are 0 at t=8, and a new start is accepted afterwards.
